// File: rtl/sr_flag_bank.sv
// ---------------------------------------------------------------------------
// sr_flag_bank
//
// Bank of N independent set/reset flags with a lowest-index-first interrupt
// presenter. Each channel latches a set event and holds it until it is
// cleared, either directly through clr or by acknowledging it while it is the
// channel being presented on irq_id. The mask only gates what is presented;
// it never alters the stored flags.
//
// Optional feature (macro SR_FLAG_OVR_EN): a saturating per-channel overrun
// counter that counts set events arriving while the flag is already set.
// Without the macro the counters and their ports do not exist and flag
// behaviour is unchanged.
//
// Parameters
//   N            number of flag channels (2..32)
//   SET_DOMINANT 1: set wins a same-cycle set/clear conflict, 0: clear wins
//   EDGE_SET     0: set[i] is level-sensitive, 1: only a rising edge sets
//   CNT_W        width of each overrun counter
//
// Ports
//   clk        clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   set[N]     per-channel set request
//   clr[N]     per-channel clear request
//   mask[N]    per-channel interrupt enable (1 = enabled)
//   ack        acknowledge of the channel currently on irq_id
//   flags[N]   registered flag state
//   irq_valid  some flag is both set and enabled
//   irq_id     lowest set-and-enabled channel, 0 when irq_valid is 0
//   ovr_cnt    (SR_FLAG_OVR_EN) channel i at [i*CNT_W +: CNT_W]
//   ovr_any    (SR_FLAG_OVR_EN) any overrun counter nonzero
// ---------------------------------------------------------------------------
module sr_flag_bank #(
    parameter int N            = 8,
    parameter int SET_DOMINANT = 1,
    parameter int EDGE_SET     = 0,
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          set,
    input  logic [N-1:0]          clr,
    input  logic [N-1:0]          mask,
    input  logic                  ack,
    output logic [N-1:0]          flags,
    output logic                  irq_valid,
    output logic [$clog2(N)-1:0]  irq_id
`ifdef SR_FLAG_OVR_EN
    ,
    output logic [N*CNT_W-1:0]    ovr_cnt,
    output logic                  ovr_any
`endif
);

    localparam int ID_W = $clog2(N);

    logic [N-1:0] set_d;
    logic [N-1:0] set_evt;
    logic [N-1:0] clr_req;
    logic [N-1:0] flags_nxt;

    // Previous value of set, used for rising-edge detection. Because it
    // resets to 0, a set input already high when reset releases counts as
    // an edge on the first clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_d <= '0;
        end else begin
            set_d <= set;
        end
    end

    // Set event per channel: the raw level, or only its rising edge.
    always_comb begin
        if (EDGE_SET != 0) begin
            set_evt = set & ~set_d;
        end else begin
            set_evt = set;
        end
    end

    // Presenter: scan from the top down so the lowest-numbered
    // set-and-enabled channel is the last one to write irq_id and wins.
    always_comb begin
        irq_valid = 1'b0;
        irq_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (flags[i] && mask[i]) begin
                irq_valid = 1'b1;
                irq_id    = ID_W'(i);
            end
        end
    end

    // Clear request: explicit clr, plus the acknowledged channel. An ack
    // with nothing presented matches no channel and is therefore ignored.
    always_comb begin
        clr_req = '0;
        for (int i = 0; i < N; i++) begin
            clr_req[i] = clr[i] | (ack & irq_valid & (irq_id == ID_W'(i)));
        end
    end

    // Next flag value; conflicts resolved by SET_DOMINANT.
    always_comb begin
        flags_nxt = flags;
        for (int i = 0; i < N; i++) begin
            unique case ({set_evt[i], clr_req[i]})
                2'b10:   flags_nxt[i] = 1'b1;
                2'b01:   flags_nxt[i] = 1'b0;
                2'b11:   flags_nxt[i] = (SET_DOMINANT != 0);
                default: flags_nxt[i] = flags[i];
            endcase
        end
    end

    // Flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags <= flags_nxt;
        end
    end

`ifdef SR_FLAG_OVR_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [N];

    // Overrun counters: any clear request zeroes the count even if the flag
    // itself survives through set dominance; otherwise a set event landing
    // on an already-set flag counts, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (clr_req[i]) begin
                    cnt_q[i] <= '0;
                end else if (set_evt[i] && flags[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Pack counters onto the flat output bus.
    always_comb begin
        ovr_cnt = '0;
        for (int i = 0; i < N; i++) begin
            ovr_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign ovr_any = |ovr_cnt;
`endif

endmodule

// File: tb/tb_sr_flag_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_bank
//
// Three instances share one stimulus stream:
//   dut 0: SET_DOMINANT=1, EDGE_SET=0
//   dut 1: SET_DOMINANT=0, EDGE_SET=0
//   dut 2: SET_DOMINANT=1, EDGE_SET=1
// A per-instance behavioural model tracks flags, the delayed set and the
// overrun counts, and every cycle all outputs are compared against it. A
// vector table and hand-written sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_sr_flag_bank;

    localparam int NI = 3;

    logic       clk;
    logic       rst;
    logic [7:0] set_i;
    logic [7:0] clr_i;
    logic [7:0] mask_i;
    logic       ack_i;

    logic [7:0] flags_o     [NI];
    logic       irq_valid_o [NI];
    logic [2:0] irq_id_o    [NI];
`ifdef SR_FLAG_OVR_EN
    logic [31:0] ovr_cnt_o  [NI];
    logic        ovr_any_o  [NI];
`endif

    int n_cmp;
    int n_fail;

    // Model state per instance.
    bit [7:0] mf   [NI];
    bit [7:0] msd  [NI];
    int       mcnt [NI][8];
    int       p_sd [NI];
    int       p_es [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sr_flag_bank #(.N(8), .SET_DOMINANT(1), .EDGE_SET(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .set(set_i), .clr(clr_i), .mask(mask_i), .ack(ack_i),
        .flags(flags_o[0]), .irq_valid(irq_valid_o[0]), .irq_id(irq_id_o[0])
`ifdef SR_FLAG_OVR_EN
        , .ovr_cnt(ovr_cnt_o[0]), .ovr_any(ovr_any_o[0])
`endif
    );

    sr_flag_bank #(.N(8), .SET_DOMINANT(0), .EDGE_SET(0), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .set(set_i), .clr(clr_i), .mask(mask_i), .ack(ack_i),
        .flags(flags_o[1]), .irq_valid(irq_valid_o[1]), .irq_id(irq_id_o[1])
`ifdef SR_FLAG_OVR_EN
        , .ovr_cnt(ovr_cnt_o[1]), .ovr_any(ovr_any_o[1])
`endif
    );

    sr_flag_bank #(.N(8), .SET_DOMINANT(1), .EDGE_SET(1), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .set(set_i), .clr(clr_i), .mask(mask_i), .ack(ack_i),
        .flags(flags_o[2]), .irq_valid(irq_valid_o[2]), .irq_id(irq_id_o[2])
`ifdef SR_FLAG_OVR_EN
        , .ovr_cnt(ovr_cnt_o[2]), .ovr_any(ovr_any_o[2])
`endif
    );

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic [7:0] m;
        logic       a;
        logic [7:0] ef;
        logic       ev;
        logic [2:0] eid;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_irq(input bit [7:0] f, input bit [7:0] m, output bit v, output int id);
        v  = 1'b0;
        id = 0;
        for (int i = 0; i < 8; i++) begin
            if (f[i] && m[i]) begin
                v  = 1'b1;
                id = i;
                break;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            mf[k]  = '0;
            msd[k] = '0;
            for (int i = 0; i < 8; i++) mcnt[k][i] = 0;
        end
    endtask

    // Advance every model by one clock using the inputs currently driven.
    task automatic model_step();
        bit v;
        int id;
        bit ev;
        bit cr;
        bit [7:0] nf;
        for (int k = 0; k < NI; k++) begin
            model_irq(mf[k], mask_i, v, id);
            nf = mf[k];
            for (int i = 0; i < 8; i++) begin
                ev = (p_es[k] != 0) ? (set_i[i] && !msd[k][i]) : set_i[i];
                cr = clr_i[i] || (ack_i && v && id == i);
                if (ev && cr)  nf[i] = (p_sd[k] != 0);
                else if (ev)   nf[i] = 1'b1;
                else if (cr)   nf[i] = 1'b0;
                if (cr)                                 mcnt[k][i] = 0;
                else if (ev && mf[k][i] && mcnt[k][i] < 15) mcnt[k][i] = mcnt[k][i] + 1;
            end
            mf[k]  = nf;
            msd[k] = set_i;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] c,
                                 input logic [7:0] m, input logic a);
        @(negedge clk);
        set_i  = s;
        clr_i  = c;
        mask_i = m;
        ack_i  = a;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        bit v;
        int id;
        for (int k = 0; k < NI; k++) begin
            model_irq(mf[k], mask_i, v, id);
            chk($sformatf("flags[dut%0d]", k), 32'(flags_o[k]), 32'(mf[k]));
            chk($sformatf("irq_valid[dut%0d]", k), 32'(irq_valid_o[k]), 32'(v));
            chk($sformatf("irq_id[dut%0d]", k), 32'(irq_id_o[k]), 32'(id));
`ifdef SR_FLAG_OVR_EN
            begin
                bit any;
                any = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("ovr_cnt[dut%0d][%0d]", k, i),
                        32'(ovr_cnt_o[k][i*4 +: 4]), 32'(mcnt[k][i]));
                    if (mcnt[k][i] != 0) any = 1'b1;
                end
                chk($sformatf("ovr_any[dut%0d]", k), 32'(ovr_any_o[k]), 32'(any));
            end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        p_sd = '{1, 0, 1};
        p_es = '{0, 0, 1};

        //          set    clr    mask   ack   flags  valid id
        tbl[0]  = '{8'h20, 8'h00, 8'hFF, 1'b0, 8'h20, 1'b1, 3'd5};
        tbl[1]  = '{8'h00, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[2]  = '{8'h24, 8'h00, 8'hFF, 1'b0, 8'h24, 1'b1, 3'd2};
        tbl[3]  = '{8'h00, 8'h00, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5};
        tbl[4]  = '{8'h00, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[5]  = '{8'h00, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0};
        tbl[6]  = '{8'h08, 8'h08, 8'hFF, 1'b0, 8'h08, 1'b1, 3'd3};
        tbl[7]  = '{8'h00, 8'h08, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[8]  = '{8'h02, 8'h00, 8'hFF, 1'b0, 8'h02, 1'b1, 3'd1};
        tbl[9]  = '{8'h02, 8'h00, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1};
        tbl[10] = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h02, 1'b0, 3'd0};
        tbl[11] = '{8'h00, 8'h00, 8'hFF, 1'b0, 8'h02, 1'b1, 3'd1};
        tbl[12] = '{8'h00, 8'h02, 8'hFF, 1'b0, 8'h00, 1'b0, 3'd0};

        rst    = 1'b1;
        set_i  = '0;
        clr_i  = '0;
        mask_i = 8'hFF;
        ack_i  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput();
        chk("reset_flags", 32'(flags_o[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] vector table");
        for (int t = 0; t < 13; t++) begin
            applyStimulus(tbl[t].s, tbl[t].c, tbl[t].m, tbl[t].a);
            checkOutput();
            chk($sformatf("tbl%0d_flags", t), 32'(flags_o[0]), 32'(tbl[t].ef));
            chk($sformatf("tbl%0d_valid", t), 32'(irq_valid_o[0]), 32'(tbl[t].ev));
            chk($sformatf("tbl%0d_id", t), 32'(irq_id_o[0]), 32'(tbl[t].eid));
            if (t == 6) chk("clr_dominant_bit3", 32'(flags_o[1][3]), 32'h0);
        end

        $display("[TB] edge-sensitive hold");
        applyStimulus(8'h00, 8'hFF, 8'hFF, 1'b0);
        checkOutput();
        for (int t = 0; t < 10; t++) begin
            applyStimulus(8'h01, 8'h00, 8'hFF, 1'b0);
            checkOutput();
            chk($sformatf("edge_hold%0d", t), 32'(flags_o[2][0]), 32'h1);
        end
        applyStimulus(8'h01, 8'h00, 8'hFF, 1'b1);
        checkOutput();
        chk("edge_ack", 32'(flags_o[2][0]), 32'h0);
        for (int t = 0; t < 3; t++) begin
            applyStimulus(8'h01, 8'h00, 8'hFF, 1'b0);
            checkOutput();
            chk($sformatf("edge_stay%0d", t), 32'(flags_o[2][0]), 32'h0);
        end

`ifdef SR_FLAG_OVR_EN
        $display("[TB] overrun saturation");
        applyStimulus(8'h00, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(8'h02, 8'h00, 8'hFF, 1'b0);
        checkOutput();
        for (int t = 0; t < 20; t++) begin
            applyStimulus(8'h02, 8'h00, 8'hFF, 1'b0);
            checkOutput();
        end
        chk("ovr_sat_cnt1", 32'(ovr_cnt_o[0][7:4]), 32'd15);
        chk("ovr_sat_any", 32'(ovr_any_o[0]), 32'h1);
        applyStimulus(8'h00, 8'h02, 8'hFF, 1'b0);
        checkOutput();
        chk("ovr_clr_cnt1", 32'(ovr_cnt_o[0][7:4]), 32'd0);
        chk("ovr_clr_flag1", 32'(flags_o[0][1]), 32'h0);
`endif

        $display("[TB] randomized run");
        for (int t = 0; t < 300; t++) begin
            applyStimulus(8'($urandom & $urandom & $urandom),
                          8'($urandom & $urandom & $urandom),
                          8'($urandom | $urandom),
                          ($urandom_range(0, 2) == 0));
            checkOutput();
        end

        $display("[TB] async reset");
        applyStimulus(8'h00, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(8'h81, 8'h00, 8'h80, 1'b0);
        checkOutput();
        chk("pre_rst_flags", 32'(flags_o[0]), 32'h81);
        chk("pre_rst_id", 32'(irq_id_o[0]), 32'd7);
        applyStimulus(8'h00, 8'h00, 8'h80, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput();
        chk("midrst_flags", 32'(flags_o[0]), 32'h0);
        chk("midrst_valid", 32'(irq_valid_o[0]), 32'h0);
        @(negedge clk);
        set_i = 8'h01;
        @(posedge clk);
        #1;
        checkOutput();
        chk("rst_hold_flags2", 32'(flags_o[2]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_step();
        @(posedge clk);
        #1;
        checkOutput();
        chk("rst_release_edge", 32'(flags_o[2][0]), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
